// File: rtl/pair_triple_frame_ctrl.sv
// pair_triple_frame_ctrl: runs FRAME_LEN 3-bit samples through a pair/triple
// hit detector, counts the hits and returns a one-word frame summary.
// Ports: clk, rst_n (async, active-low), start (level, sampled in idle),
//   in_val/in_rdy/in_data[2:0] sample handshake,
//   out_val/out_rdy/out_count[CNT_W-1:0]/out_all summary handshake,
//   busy (high while scanning or reporting).
// Optional macro PTD_RUN_TRACK_EN adds run_max[CNT_W-1:0], the longest run
//   of consecutive hit samples in the frame.
module pair_triple_frame_ctrl #(
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [2:0]       in_data,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [CNT_W-1:0] out_count,
   output logic             out_all,
   output logic             busy
`ifdef PTD_RUN_TRACK_EN
   ,
   output logic [CNT_W-1:0] run_max
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      REPORT
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(FRAME_LEN);

   state_t           state;
   state_t           state_d;
   logic             hit;
   logic             accept;
   logic             last;
   logic             clr;
   logic             load;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] sum;

   // pair (in0 & in1) or lone in2 with both low bits clear
   assign hit = (in_data[0] & in_data[1]) |
                (~in_data[0] & ~in_data[1] & in_data[2]);

   assign in_rdy = (state == SCAN);
   assign busy   = (state != IDLE);
   assign accept = in_val & in_rdy;
   assign last   = (idx == LAST_IDX);
   assign sum    = acc + CNT_W'(hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      clr     = 1'b0;
      load    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               clr     = 1'b1;
            end
         end
         SCAN: begin
            if (accept && last) begin
               state_d = REPORT;
               load    = 1'b1;
            end
         end
         REPORT: begin
            // a start on the handshake cycle chains straight into a new frame
            if (out_rdy) begin
               if (start) begin
                  state_d = SCAN;
                  clr     = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         acc <= '0;
      end else if (clr) begin
         idx <= '0;
         acc <= '0;
      end else if (accept) begin
         idx <= idx + 1'b1;
         acc <= sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_val   <= 1'b0;
         out_count <= '0;
         out_all   <= 1'b0;
      end else begin
         out_val <= (state_d == REPORT);
         if (load) begin
            out_count <= sum;
            out_all   <= (sum == FULL);
         end
      end
   end

`ifdef PTD_RUN_TRACK_EN
   logic [CNT_W-1:0] run_cur;
   logic [CNT_W-1:0] run_best;
   logic [CNT_W-1:0] run_nxt;
   logic [CNT_W-1:0] best_nxt;

   assign run_nxt  = hit ? run_cur + 1'b1 : '0;
   assign best_nxt = (run_nxt > run_best) ? run_nxt : run_best;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cur  <= '0;
         run_best <= '0;
         run_max  <= '0;
      end else begin
         if (clr) begin
            run_cur  <= '0;
            run_best <= '0;
         end else if (accept) begin
            run_cur  <= run_nxt;
            run_best <= best_nxt;
         end
         if (load) begin
            run_max <= best_nxt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pair_triple_frame_ctrl.sv
// tb_pair_triple_frame_ctrl: directed and random frames for
// pair_triple_frame_ctrl against a sample-list reference model.
module tb_pair_triple_frame_ctrl;

   localparam int FL = 8;
   localparam int CW = $clog2(FL + 1);

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          start   = 1'b0;
   logic          in_val  = 1'b0;
   logic [2:0]    in_data = 3'b000;
   logic          out_rdy = 1'b0;
   logic          in_rdy;
   logic          out_val;
   logic [CW-1:0] out_count;
   logic          out_all;
   logic          busy;
`ifdef PTD_RUN_TRACK_EN
   logic [CW-1:0] run_max;
`endif

   int         n_vec = 0;
   int         n_err = 0;
   logic [2:0] fq[$];
   bit         in_scan = 1'b0;

   pair_triple_frame_ctrl #(.FRAME_LEN(FL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_val    (in_val),
      .in_rdy    (in_rdy),
      .in_data   (in_data),
      .out_val   (out_val),
      .out_rdy   (out_rdy),
      .out_count (out_count),
      .out_all   (out_all),
      .busy      (busy)
`ifdef PTD_RUN_TRACK_EN
      ,
      .run_max   (run_max)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_hit(input logic [2:0] s);
      return ((s[0] && s[1]) || (!s[0] && !s[1] && s[2])) ? 1 : 0;
   endfunction

   function automatic int ref_count();
      int n = 0;
      foreach (fq[i]) n += ref_hit(fq[i]);
      return n;
   endfunction

   function automatic int ref_run();
      int cur  = 0;
      int best = 0;
      foreach (fq[i]) begin
         cur = ref_hit(fq[i]) ? cur + 1 : 0;
         if (cur > best) best = cur;
      end
      return best;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_rdy", in_rdy, 1);
      chk("start_busy", busy, 1);
   endtask

   task automatic feed(input int gmin, input int gmax);
      int g;
      for (int i = 0; i < fq.size(); i++) begin
         g = $urandom_range(gmax, gmin);
         for (int k = 0; k < g; k++) begin
            in_val  = 1'b0;
            start   = 1'($urandom_range(1, 0));
            in_data = 3'($urandom);
            tick();
            chk("gap_val", out_val, 0);
            chk("gap_rdy", in_rdy, 1);
         end
         start   = 1'b0;
         in_val  = 1'b1;
         in_data = fq[i];
         tick();
         in_val = 1'b0;
         if (i < fq.size() - 1) chk("early_val", out_val, 0);
      end
      chk("res_val", out_val, 1);
      chk("res_cnt", out_count, ref_count());
      chk("res_all", out_all, (ref_count() == FL) ? 1 : 0);
      chk("res_rdy", in_rdy, 0);
      chk("res_busy", busy, 1);
`ifdef PTD_RUN_TRACK_EN
      chk("res_run", run_max, ref_run());
`endif
   endtask

   task automatic report(input int hold, input bit chain);
      int exp = ref_count();
      for (int k = 0; k < hold; k++) begin
         out_rdy = 1'b0;
         start   = 1'($urandom_range(1, 0));
         in_val  = 1'($urandom_range(1, 0));
         tick();
         chk("hold_val", out_val, 1);
         chk("hold_cnt", out_count, exp);
         chk("hold_rdy", in_rdy, 0);
      end
      in_val  = 1'b0;
      out_rdy = 1'b1;
      start   = chain;
      tick();
      out_rdy = 1'b0;
      start   = 1'b0;
      chk("post_val", out_val, 0);
      chk("keep_cnt", out_count, exp);
      if (chain) begin
         chk("chain_rdy", in_rdy, 1);
         chk("chain_busy", busy, 1);
      end else begin
         chk("idle_rdy", in_rdy, 0);
         chk("idle_busy", busy, 0);
      end
      in_scan = chain;
   endtask

   task automatic frame(input int gmin, input int gmax, input int hold,
                        input bit chain);
      if (!in_scan) start_frame();
      feed(gmin, gmax);
      report(hold, chain);
   endtask

   task automatic fill(input logic [2:0] v);
      fq.delete();
      for (int i = 0; i < FL; i++) fq.push_back(v);
   endtask

   initial begin
      logic [2:0] pat[8];
      #12;
      chk("rst_val", out_val, 0);
      chk("rst_rdy", in_rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", out_count, 0);
      chk("rst_all", out_all, 0);
      rst_n = 1'b1;
      tick();

      // samples offered in idle are not taken
      in_val = 1'b1;
      repeat (3) begin
         tick();
         chk("idle_norpy", in_rdy, 0);
         chk("idle_nobusy", busy, 0);
      end
      in_val = 1'b0;

      fq.delete();
      for (int i = 0; i < FL; i++) fq.push_back(3'(i));
      frame(0, 0, 0, 1'b0);

      fill(3'b111);
      frame(0, 0, 0, 1'b0);

      fill(3'b100);
      frame(2, 2, 5, 1'b0);

      fill(3'b111);
      frame(0, 1, 1, 1'b1);
      fill(3'b010);
      frame(0, 0, 0, 1'b0);

      pat = '{3'b111, 3'b111, 3'b000, 3'b100,
              3'b011, 3'b111, 3'b001, 3'b011};
      fq.delete();
      foreach (pat[i]) fq.push_back(pat[i]);
      frame(0, 1, 2, 1'b0);

      for (int f = 0; f < 40; f++) begin
         fq.delete();
         for (int i = 0; i < FL; i++) fq.push_back(3'($urandom));
         frame(0, 2, $urandom_range(3, 0),
               (f == 39) ? 1'b0 : 1'($urandom_range(1, 0)));
      end

      fill(3'b111);
      frame(0, 0, 0, 1'b0);

      // partial frame then an asynchronous reset between edges
      start_frame();
      in_val  = 1'b1;
      in_data = 3'b111;
      repeat (4) tick();
      in_val = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_val", out_val, 0);
      chk("arst_rdy", in_rdy, 0);
      chk("arst_busy", busy, 0);
      chk("arst_cnt", out_count, 0);
      chk("arst_all", out_all, 0);
      #2;
      rst_n = 1'b1;
      in_scan = 1'b0;
      tick();
      chk("arst_idle", busy, 0);

      fill(3'b000);
      frame(0, 1, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
